// File: rtl/wb_write_queue.sv
// In-order writeback queue that feeds the register file's single write port at
// one write per cycle and exposes pending values to the forwarding path.
module wb_write_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_value,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]        mem_value,
  output logic                         in_ready,
  output logic [ADDR_WIDTH-1:0]        rd_address,
  output logic [DATA_WIDTH-1:0]        rd_value,
  output logic                         reg_write,
  input  logic [ADDR_WIDTH-1:0]        lookup_address,
  output logic                         lookup_hit,
  output logic [DATA_WIDTH-1:0]        lookup_value,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] ent_rd_q  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_val_q [DEPTH];

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] rd_address_q, rd_address_d;
  logic [DATA_WIDTH-1:0] rd_value_q, rd_value_d;

  logic                  acc_mem, acc_alu, pop;
  logic [PW-1:0]         alu_slot;
  logic [PW-1:0]         lk_idx;

  // Two free slots are needed so both producers can always be taken together.
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign acc_mem  = in_ready && mem_valid && (mem_rd != '0);
  assign acc_alu  = in_ready && alu_valid && (alu_rd != '0);
  assign pop      = (count_q != '0);
  assign alu_slot = acc_mem ? tail_q + PW'(1) : tail_q;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q + PW'(acc_mem) + PW'(acc_alu);
    count_d      = count_q + CW'(acc_mem) + CW'(acc_alu) - CW'(pop);
    reg_write_d  = pop;
    rd_address_d = rd_address_q;
    rd_value_d   = rd_value_q;
    if (pop) begin
      head_d       = head_q + PW'(1);
      rd_address_d = ent_rd_q[head_q];
      rd_value_d   = ent_val_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      rd_address_q <= '0;
      rd_value_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      rd_address_q <= rd_address_d;
      rd_value_q   <= rd_value_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (acc_mem) begin
      ent_rd_q[tail_q]  <= mem_rd;
      ent_val_q[tail_q] <= mem_value;
    end
    if (acc_alu) begin
      ent_rd_q[alu_slot]  <= alu_rd;
      ent_val_q[alu_slot] <= alu_value;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; the output
  // register is older than every queued entry, so it is considered first.
  always_comb begin
    lookup_hit   = 1'b0;
    lookup_value = '0;
    lk_idx       = head_q;
    if (reg_write_q && (rd_address_q == lookup_address)) begin
      lookup_hit   = 1'b1;
      lookup_value = rd_value_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (ent_rd_q[lk_idx] == lookup_address)) begin
        lookup_hit   = 1'b1;
        lookup_value = ent_val_q[lk_idx];
      end
    end
    if (lookup_address == '0) begin
      lookup_hit   = 1'b0;
      lookup_value = '0;
    end
  end

  assign rd_address = rd_address_q;
  assign rd_value   = rd_value_q;
  assign reg_write  = reg_write_q;
  assign count      = count_q;
  assign empty      = (count_q == '0);

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side companion to the register file: collects writeback results from the ALU and load/store paths, queues them in order, and drives the register file's single write port at one write per cycle.
- Sits between the MEM/WB pipeline boundary and the register file write port (rd_address, rd_value, reg_write).
- Exposes a combinational lookup of pending, not-yet-committed values so the forwarding module can bypass them.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2
- DATA_WIDTH, 32, register value width
- ADDR_WIDTH, 5, register index width (32 registers)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_value  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load result present this cycle
- mem_rd  input  ADDR_WIDTH  load destination register
- mem_value  input  DATA_WIDTH  load data
- in_ready  output  1  queue can accept both producers this cycle
- rd_address  output  ADDR_WIDTH  register file write index
- rd_value  output  DATA_WIDTH  register file write data
- reg_write  output  1  register file write enable
- lookup_address  input  ADDR_WIDTH  forwarding query index
- lookup_hit  output  1  a pending write to lookup_address exists
- lookup_value  output  DATA_WIDTH  youngest pending value for lookup_address
- count  output  $clog2(DEPTH+1)  occupied entries
- empty  output  1  count == 0

Behaviour:
- Reset (async, active-high): head/tail pointers = 0, count = 0, empty = 1, in_ready = 1, reg_write = 0, rd_address = 0, rd_value = 0. Pending entries are discarded, including on reset mid-drain; lookup_hit = 0 while reset is asserted.
- in_ready = (count <= DEPTH-2). This is combinational from registered count only; no dependence on the valid inputs.
- Enqueue happens on a rising edge when in_ready = 1:
  - Producer ignored if its valid = 0, or if its rd == 0 (writes to r0 are dropped; never enqueued, never written).
  - Both valid: mem entry is older and enqueued first, then alu entry. Tail advances by 0, 1 or 2.
  - A valid input while in_ready = 0 is ignored; the producer must hold (stall) until accepted.
- Dequeue: on each rising edge with count > 0 (pre-edge), the head entry is loaded into the output register. reg_write = 1, rd_address = head.rd, rd_value = head.value, and head advances.
  - With count == 0, reg_write = 0 on the next cycle; rd_address and rd_value hold their last values.
  - reg_write is a one-cycle pulse per entry; back-to-back entries give consecutive pulses.
- Latency: an entry accepted at edge N drives the write port during the cycle after edge N+1 at the earliest, when the queue was empty.
- Simultaneous enqueue and dequeue on the same edge is allowed: count_next = count + accepted - popped. Count never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Lookup is combinational over the output register (while reg_write = 1) plus all occupied queue entries.
  - The youngest match wins; queue entries are younger than the output register.
  - lookup_address == 0 gives lookup_hit = 0.
  - Inputs arriving in the current cycle are not searched.
  - No match gives lookup_hit = 0 and lookup_value = 0.
- Program order between producers is preserved. The same rd enqueued twice results in two writes in order, so the final register value is the younger one.

Test Plan:
- Assert reset mid-stream with 3 entries queued -> immediately reg_write = 0, count = 0, empty = 1, in_ready = 1, lookup_hit = 0. After release, no stale writes appear.
- alu_valid with rd = 1, value = 5 on an empty queue at edge N -> at edge N+1: reg_write = 1, rd_address = 1, rd_value = 5. At edge N+2: reg_write = 0, empty = 1.
- mem (rd = 2, value = 7) and alu (rd = 31, value = 9) in the same cycle -> consecutive write pulses: r2 = 7, then r31 = 9. count goes 2 -> 1 -> 0.
- mem (rd = 3, value = 1) and alu (rd = 3, value = 2) queued; lookup_address = 3:
  - lookup_hit = 1 and lookup_value = 2 until both are drained, then lookup_hit = 0.
  - Writes occur in order: 1, then 2.
- alu_valid with rd = 0, value = 0xDEAD -> nothing enqueued, count stays 0, no reg_write. lookup_address = 0 gives lookup_hit = 0.
- DEPTH = 4, both producers valid on consecutive edges -> count = 2, then 3. in_ready drops to 0 and the held inputs are not accepted until a drain brings count to 2. No entry is lost or duplicated.
